// File: rtl/seg7_time_display.sv
// rtl/seg7_time_display.sv - six-digit multiplexed seven-segment driver for the clock display
// Scans hh:mm:ss one digit at a time, blinks the edited field and flashes decimal points on alarm.
module seg7_time_display #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 50
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [4:0] hours_in,
   input  logic [5:0] minutes_in,
   input  logic [5:0] seconds_in,
   input  logic [2:0] display_mode_in,
   input  logic       alarm_active_in,
   output logic [5:0] an_n,
   output logic [6:0] seg_n,
   output logic       dp_n
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [RW-1:0] refresh_cnt;
   logic [2:0]    digit_idx;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic [4:0]    snap_hours;
   logic [5:0]    snap_minutes;
   logic [5:0]    snap_seconds;
   logic [2:0]    snap_mode;
   logic          snap_alarm;

   logic          tick;
   logic          frame_end;

   assign tick      = (refresh_cnt == RW'(REFRESH_DIV - 1));
   assign frame_end = tick && (digit_idx == 3'd5);

   function automatic logic [6:0] seg_code(input logic [3:0] v);
      case (v)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   logic [4:0] hr_tens, hr_ones;
   logic [5:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       hr_bad, min_bad, sec_bad;
   logic       hr_blink, min_blink, sec_blink;
   logic [3:0] digit;
   logic       field_bad, field_blink;
   logic [6:0] seg_next;
   logic [5:0] an_next;
   logic       dp_next;

   always_comb begin
      hr_tens   = snap_hours / 5'd10;
      hr_ones   = snap_hours % 5'd10;
      min_tens  = snap_minutes / 6'd10;
      min_ones  = snap_minutes % 6'd10;
      sec_tens  = snap_seconds / 6'd10;
      sec_ones  = snap_seconds % 6'd10;
      hr_bad    = (snap_hours > 5'd23);
      min_bad   = (snap_minutes > 6'd59);
      sec_bad   = (snap_seconds > 6'd59);
      hr_blink  = (snap_mode == 3'd1) || (snap_mode == 3'd4);
      min_blink = (snap_mode == 3'd2) || (snap_mode == 3'd5);
      sec_blink = (snap_mode == 3'd3);

      digit       = 4'd0;
      field_bad   = 1'b0;
      field_blink = 1'b0;
      case (digit_idx)
         3'd0: begin digit = sec_ones[3:0]; field_bad = sec_bad; field_blink = sec_blink; end
         3'd1: begin digit = sec_tens[3:0]; field_bad = sec_bad; field_blink = sec_blink; end
         3'd2: begin digit = min_ones[3:0]; field_bad = min_bad; field_blink = min_blink; end
         3'd3: begin digit = min_tens[3:0]; field_bad = min_bad; field_blink = min_blink; end
         3'd4: begin digit = hr_ones[3:0];  field_bad = hr_bad;  field_blink = hr_blink;  end
         3'd5: begin digit = hr_tens[3:0];  field_bad = hr_bad;  field_blink = hr_blink;  end
         default: ;
      endcase

      // A hidden blinking field blanks even when it would otherwise show a dash.
      if (blink_phase && field_blink)
         seg_next = 7'h7F;
      else if (field_bad)
         seg_next = 7'h3F;
      else
         seg_next = seg_code(digit);

      an_next = ~(6'b000001 << digit_idx);
      dp_next = snap_alarm ? blink_phase : !((digit_idx == 3'd2) || (digit_idx == 3'd4));
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt  <= '0;
         digit_idx    <= 3'd0;
         frame_cnt    <= '0;
         blink_phase  <= 1'b0;
         snap_hours   <= 5'd0;
         snap_minutes <= 6'd0;
         snap_seconds <= 6'd0;
         snap_mode    <= 3'd0;
         snap_alarm   <= 1'b0;
         an_n         <= 6'h3F;
         seg_n        <= 7'h7F;
         dp_n         <= 1'b1;
      end else begin
         an_n  <= an_next;
         seg_n <= seg_next;
         dp_n  <= dp_next;

         if (tick) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end

         // Inputs are frozen for the whole next frame so digit pairs never tear.
         if (frame_end) begin
            snap_hours   <= hours_in;
            snap_minutes <= minutes_in;
            snap_seconds <= seconds_in;
            snap_mode    <= display_mode_in;
            snap_alarm   <= alarm_active_in;
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_time_display.sv
// tb/tb_seg7_time_display.sv - directed bench for seg7_time_display
// Uses REFRESH_DIV=4, BLINK_FRAMES=2; outputs are sampled on the falling edge.
module tb_seg7_time_display;

   logic       sys_clk;
   logic       rst_n;
   logic [4:0] hours_in;
   logic [5:0] minutes_in;
   logic [5:0] seconds_in;
   logic [2:0] display_mode_in;
   logic       alarm_active_in;
   logic [5:0] an_n;
   logic [6:0] seg_n;
   logic       dp_n;

   int checks;
   int failures;

   seg7_time_display #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .hours_in        (hours_in),
      .minutes_in      (minutes_in),
      .seconds_in      (seconds_in),
      .display_mode_in (display_mode_in),
      .alarm_active_in (alarm_active_in),
      .an_n            (an_n),
      .seg_n           (seg_n),
      .dp_n            (dp_n)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One digit slot: four falling-edge samples of anode, segments and dp.
   task automatic check_digit(input string tag, input int d, input logic [6:0] seg_exp,
                              input logic dp_exp);
      logic [5:0] an_tab [6];
      an_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
      for (int c = 0; c < 4; c++) begin
         @(negedge sys_clk);
         chk($sformatf("%s d%0d c%0d an", tag, d, c), {2'b00, an_n}, {2'b00, an_tab[d]});
         chk($sformatf("%s d%0d c%0d seg", tag, d, c), {1'b0, seg_n}, {1'b0, seg_exp});
         chk($sformatf("%s d%0d c%0d dp", tag, d, c), {7'd0, dp_n}, {7'd0, dp_exp});
      end
   endtask

   task automatic check_frame(input string tag, input logic [5:0][6:0] segs,
                              input logic [5:0] dps);
      for (int d = 0; d < 6; d++)
         check_digit(tag, d, segs[d], dps[d]);
   endtask

   localparam logic [5:0] DP_SEP  = 6'b101011;
   localparam logic [5:0] DP_ALL  = 6'b000000;
   localparam logic [5:0] DP_NONE = 6'b111111;

   initial begin
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      hours_in        = 5'd12;
      minutes_in      = 6'd34;
      seconds_in      = 6'd56;
      display_mode_in = 3'd0;
      alarm_active_in = 1'b0;

      @(negedge sys_clk);
      chk("reset an", {2'b00, an_n}, 8'h3F);
      chk("reset seg", {1'b0, seg_n}, 8'h7F);
      chk("reset dp", {7'd0, dp_n}, 8'h01);
      @(negedge sys_clk);
      rst_n = 1'b1;

      check_frame("f0", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, DP_SEP);

      // Frame 1: 12:34:56; minutes change while digit 1 is being scanned.
      check_digit("f1", 0, 7'h02, 1'b1);
      minutes_in = 6'd35;
      check_digit("f1", 1, 7'h12, 1'b1);
      check_digit("f1", 2, 7'h19, 1'b0);
      check_digit("f1", 3, 7'h30, 1'b1);
      check_digit("f1", 4, 7'h24, 1'b0);
      check_digit("f1", 5, 7'h79, 1'b1);

      // Frame 2 is a hidden blink half, but mode 0 keeps every digit visible.
      alarm_active_in = 1'b1;
      check_frame("f2", {7'h79, 7'h24, 7'h30, 7'h12, 7'h12, 7'h02}, DP_SEP);

      // Alarm captured: frame 3 hidden half, frame 4 visible half.
      check_frame("f3 alarm", {7'h79, 7'h24, 7'h30, 7'h12, 7'h12, 7'h02}, DP_NONE);
      hours_in        = 5'd25;
      minutes_in      = 6'd60;
      alarm_active_in = 1'b0;
      check_frame("f4 alarm", {7'h79, 7'h24, 7'h30, 7'h12, 7'h12, 7'h02}, DP_ALL);

      check_frame("f5 invalid", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h12, 7'h02}, DP_SEP);

      // Asynchronous reset while digit 3 is lit.
      check_digit("f6", 0, 7'h02, 1'b1);
      check_digit("f6", 1, 7'h12, 1'b1);
      check_digit("f6", 2, 7'h3F, 1'b0);
      @(negedge sys_clk);
      chk("f6 d3 an", {2'b00, an_n}, 8'h37);
      rst_n = 1'b0;
      #1;
      chk("async an", {2'b00, an_n}, 8'h3F);
      chk("async seg", {1'b0, seg_n}, 8'h7F);
      chk("async dp", {7'd0, dp_n}, 8'h01);
      hours_in        = 5'd12;
      minutes_in      = 6'd34;
      seconds_in      = 6'd56;
      display_mode_in = 3'd2;
      @(negedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b1;

      check_frame("r0", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, DP_SEP);
      check_frame("r1 blink", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, DP_SEP);
      check_frame("r2 blink", {7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02}, DP_SEP);
      check_frame("r3 blink", {7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02}, DP_SEP);
      check_frame("r4 blink", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, DP_SEP);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
